// File: rtl/hazard_controller.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_controller
//  Description : Hazard detection and sequencing for the 5-stage MIPS core.
//                Detects load-use, early-branch operand and MDU result
//                hazards, drives F/D stall and D/E flush, selects decode-stage
//                branch forwarding and sequences the multi-cycle MDU with a
//                busy down-counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module hazard_controller #(
    parameter int MUL_LATENCY = 3,
    parameter int DIV_LATENCY = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] rs_D,
    input  logic [4:0] rt_D,
    input  logic       branch_D,
    input  logic       branch_taken_D,
    input  logic       mdu_use_D,
    input  logic [4:0] write_reg_E,
    input  logic       reg_write_E,
    input  logic       mem_to_reg_E,
    input  logic       mdu_start_E,
    input  logic       mdu_op_E,
    input  logic [4:0] write_reg_M,
    input  logic       reg_write_M,
    input  logic       mem_to_reg_M,
    output logic       stall_F,
    output logic       stall_D,
    output logic       flush_D,
    output logic       flush_E,
    output logic       forward_a_D,
    output logic       forward_b_D,
    output logic       mdu_busy,
    output logic       mdu_done
);

    // Counter must hold DIV_LATENCY-1; a single bit is the floor.
    localparam int CNT_W = (DIV_LATENCY > 1) ? $clog2(DIV_LATENCY) : 1;
    localparam logic [CNT_W-1:0] c_MUL_LOAD = CNT_W'(MUL_LATENCY - 1);
    localparam logic [CNT_W-1:0] c_DIV_LOAD = CNT_W'(DIV_LATENCY - 1);
    localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;

    logic w_lw_stall;
    logic w_br_stall;
    logic w_mdu_stall;
    logic w_stall;

    // Register 0 is hard-wired, so it never creates a dependence.
    function automatic logic f_match(input logic [4:0] x, input logic [4:0] r);
        return (x != 5'd0) && (x == r);
    endfunction

    // A load in E cannot forward to the instruction in D in time.
    assign w_lw_stall = mem_to_reg_E && reg_write_E &&
                        (f_match(write_reg_E, rs_D) || f_match(write_reg_E, rt_D));

    // The branch compares in D, so an E producer (any) or an M load is too late.
    assign w_br_stall = branch_D &&
                        ((reg_write_E  && (f_match(write_reg_E, rs_D) || f_match(write_reg_E, rt_D))) ||
                         (mem_to_reg_M && (f_match(write_reg_M, rs_D) || f_match(write_reg_M, rt_D))));

    // HI/LO users wait for a running operation or one being launched from E.
    assign w_mdu_stall = mdu_use_D &&
                         ((r_state == S_BUSY) || ((r_state == S_IDLE) && mdu_start_E));

    assign w_stall = w_lw_stall || w_br_stall || w_mdu_stall;

    // Pipeline controls are held inactive while the core is in reset.
    assign stall_F = rst_n && w_stall;
    assign stall_D = rst_n && w_stall;
    assign flush_E = rst_n && w_stall;
    // A stall keeps the branch in D; it re-resolves and squashes afterwards.
    assign flush_D = rst_n && branch_taken_D && !w_stall;

    // ALU result sitting in M is forwarded to the D-stage comparator.
    assign forward_a_D = reg_write_M && !mem_to_reg_M && f_match(write_reg_M, rs_D);
    assign forward_b_D = reg_write_M && !mem_to_reg_M && f_match(write_reg_M, rt_D);

    assign mdu_busy = (r_state == S_BUSY);
    assign mdu_done = (r_state == S_BUSY) && (r_cnt == '0);

    // MDU sequencer: load latency-1 on start, count down, finish at zero.
    // Starts while busy are ignored; a flush of E does not cancel a start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (mdu_start_E) begin
                        r_cnt   <= mdu_op_E ? c_DIV_LOAD : c_MUL_LOAD;
                        r_state <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - c_CNT_ONE;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hazard_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hazard_controller
//  Description : Scoreboard bench for hazard_controller. Stimulus applies one
//                input vector per cycle and queues the outputs a cycle-level
//                reference model predicts; a monitor pops and compares them.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_controller;

    localparam int MUL_L = 3;
    localparam int DIV_L = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [4:0] rs_D = '0, rt_D = '0, write_reg_E = '0, write_reg_M = '0;
    logic       branch_D = 0, branch_taken_D = 0, mdu_use_D = 0;
    logic       reg_write_E = 0, mem_to_reg_E = 0, mdu_start_E = 0, mdu_op_E = 0;
    logic       reg_write_M = 0, mem_to_reg_M = 0;
    logic       stall_F, stall_D, flush_D, flush_E;
    logic       forward_a_D, forward_b_D, mdu_busy, mdu_done;

    always #5 clk = ~clk;

    hazard_controller #(
        .MUL_LATENCY (MUL_L),
        .DIV_LATENCY (DIV_L)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .rs_D           (rs_D),
        .rt_D           (rt_D),
        .branch_D       (branch_D),
        .branch_taken_D (branch_taken_D),
        .mdu_use_D      (mdu_use_D),
        .write_reg_E    (write_reg_E),
        .reg_write_E    (reg_write_E),
        .mem_to_reg_E   (mem_to_reg_E),
        .mdu_start_E    (mdu_start_E),
        .mdu_op_E       (mdu_op_E),
        .write_reg_M    (write_reg_M),
        .reg_write_M    (reg_write_M),
        .mem_to_reg_M   (mem_to_reg_M),
        .stall_F        (stall_F),
        .stall_D        (stall_D),
        .flush_D        (flush_D),
        .flush_E        (flush_E),
        .forward_a_D    (forward_a_D),
        .forward_b_D    (forward_b_D),
        .mdu_busy       (mdu_busy),
        .mdu_done       (mdu_done)
    );

    typedef struct {
        logic       rst_n;
        logic [4:0] rs, rt;
        logic       branch, taken, mdu_use;
        logic [4:0] wr_e;
        logic       rw_e, m2r_e, start, op;
        logic [4:0] wr_m;
        logic       rw_m, m2r_m;
    } stim_t;

    typedef struct {
        logic stall, flush_d, fwd_a, fwd_b, busy, done;
        int   cyc;
    } exp_t;

    exp_t exp_q[$];
    int   cyc      = 0;
    int   mdu_end  = -1;   // cycle index in which the running op completes
    int   n_checks = 0;
    int   n_pass   = 0;

    function automatic stim_t quiet();
        stim_t s;
        s = '{default: 0};
        s.rst_n = 1'b1;
        return s;
    endfunction

    // Does producer register w feed either source operand of the D instruction?
    function automatic bit feeds(input logic [4:0] w, input logic [4:0] a, input logic [4:0] b);
        return (w != 0) && ((w == a) || (w == b));
    endfunction

    // Drive one cycle of inputs and queue the predicted outputs for it.
    task automatic apply(input stim_t s);
        exp_t e;
        bit   busy, hz;
        @(posedge clk);
        #1;
        rst_n = s.rst_n; rs_D = s.rs; rt_D = s.rt;
        branch_D = s.branch; branch_taken_D = s.taken; mdu_use_D = s.mdu_use;
        write_reg_E = s.wr_e; reg_write_E = s.rw_e; mem_to_reg_E = s.m2r_e;
        mdu_start_E = s.start; mdu_op_E = s.op;
        write_reg_M = s.wr_m; reg_write_M = s.rw_m; mem_to_reg_M = s.m2r_m;
        cyc++;
        if (!s.rst_n) mdu_end = -1;
        busy = s.rst_n && (cyc <= mdu_end);
        hz = (s.m2r_e && s.rw_e && feeds(s.wr_e, s.rs, s.rt)) ||
             (s.branch && ((s.rw_e && feeds(s.wr_e, s.rs, s.rt)) ||
                           (s.m2r_m && feeds(s.wr_m, s.rs, s.rt)))) ||
             (s.mdu_use && (busy || s.start));
        e.cyc     = cyc;
        e.busy    = busy;
        e.done    = s.rst_n && (cyc == mdu_end);
        e.stall   = s.rst_n && hz;
        e.flush_d = s.rst_n && s.taken && !hz;
        e.fwd_a   = s.rw_m && !s.m2r_m && feeds(s.wr_m, s.rs, s.rs);
        e.fwd_b   = s.rw_m && !s.m2r_m && feeds(s.wr_m, s.rt, s.rt);
        exp_q.push_back(e);
        if (s.rst_n && s.start && !busy) mdu_end = cyc + (s.op ? DIV_L : MUL_L);
    endtask

    task automatic chk(input string nm, input int c, input logic act, input logic req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s cycle %0d: got %b expected %b", nm, c, act, req);
    endtask

    // Monitor: outputs are valid every cycle, compared mid-cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("stall_F",     e.cyc, stall_F,     e.stall);
            chk("stall_D",     e.cyc, stall_D,     e.stall);
            chk("flush_E",     e.cyc, flush_E,     e.stall);
            chk("flush_D",     e.cyc, flush_D,     e.flush_d);
            chk("forward_a_D", e.cyc, forward_a_D, e.fwd_a);
            chk("forward_b_D", e.cyc, forward_b_D, e.fwd_b);
            chk("mdu_busy",    e.cyc, mdu_busy,    e.busy);
            chk("mdu_done",    e.cyc, mdu_done,    e.done);
        end
    end

    initial begin
        stim_t s;

        // Reset with a load-use pattern present: controls must stay low.
        s = quiet(); s.rst_n = 0; s.m2r_e = 1; s.rw_e = 1; s.wr_e = 5; s.rs = 5; s.taken = 1;
        apply(s); apply(s);

        // Load-use, then the same with register 0.
        s = quiet(); s.m2r_e = 1; s.rw_e = 1; s.wr_e = 5; s.rs = 5; apply(s);
        s = quiet(); s.m2r_e = 1; s.rw_e = 1; apply(s);

        // Branch after ALU producer: one stall, then forward from M.
        s = quiet(); s.branch = 1; s.rt = 7; s.rw_e = 1; s.wr_e = 7; apply(s);
        s = quiet(); s.branch = 1; s.rt = 7; s.rw_m = 1; s.wr_m = 7; apply(s);

        // Branch after load producer: two stalls, no forward afterwards.
        s = quiet(); s.branch = 1; s.rs = 3; s.rw_e = 1; s.m2r_e = 1; s.wr_e = 3; apply(s);
        s = quiet(); s.branch = 1; s.rs = 3; s.rw_m = 1; s.m2r_m = 1; s.wr_m = 3; apply(s);
        s = quiet(); s.branch = 1; s.rs = 3; apply(s);

        // Taken branch held by a load-use stall, then squashed.
        s = quiet(); s.branch = 1; s.taken = 1; s.rs = 9; s.rw_e = 1; s.m2r_e = 1; s.wr_e = 9; apply(s);
        s = quiet(); s.branch = 1; s.taken = 1; s.rs = 9; apply(s);

        // Divide with mflo waiting in D, then multiply.
        s = quiet(); s.start = 1; s.op = 1; s.mdu_use = 1; apply(s);
        s = quiet(); s.mdu_use = 1; repeat (DIV_L + 1) apply(s);
        s = quiet(); s.start = 1; s.op = 0; s.mdu_use = 1; apply(s);
        s = quiet(); s.mdu_use = 1; repeat (MUL_L + 1) apply(s);

        // Reset in the middle of a divide, then a clean multiply.
        s = quiet(); s.start = 1; s.op = 1; apply(s);
        s = quiet(); s.mdu_use = 1; repeat (3) apply(s);
        s.rst_n = 0; s.branch = 1; s.rw_e = 1; s.wr_e = 2; s.rs = 2; apply(s); apply(s);
        s = quiet(); s.start = 1; s.op = 0; apply(s);
        s = quiet(); s.mdu_use = 1; repeat (MUL_L + 1) apply(s);

        // Randomized traffic over a small register range for frequent hits.
        repeat (800) begin
            s.rst_n   = ($urandom_range(0, 79) != 0);
            s.rs      = 5'($urandom_range(0, 3));
            s.rt      = 5'($urandom_range(0, 3));
            s.branch  = $urandom_range(0, 2) == 0;
            s.taken   = $urandom_range(0, 2) == 0;
            s.mdu_use = $urandom_range(0, 2) == 0;
            s.wr_e    = 5'($urandom_range(0, 3));
            s.rw_e    = $urandom_range(0, 1) == 0;
            s.m2r_e   = $urandom_range(0, 2) == 0;
            s.start   = $urandom_range(0, 3) == 0;
            s.op      = $urandom_range(0, 1) == 0;
            s.wr_m    = 5'($urandom_range(0, 3));
            s.rw_m    = $urandom_range(0, 1) == 0;
            s.m2r_m   = $urandom_range(0, 2) == 0;
            apply(s);
        end

        // Bounded drain of the scoreboard.
        for (int i = 0; i < 5 && exp_q.size() != 0; i++) @(negedge clk);
        #1;
        n_checks++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL drain: %0d entries left, expected 0", exp_q.size());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hazard_controller.md
# hazard_controller

Pipeline hazard and sequencing controller for the 5-stage MIPS core, paired with the EX-stage forwarding unit. It detects hazards that forwarding cannot resolve and drives the F/D stall and D/E flush controls:

- load-use dependences;
- early-branch operand dependences;
- decode-stage branch forwarding;
- the taken-branch squash.

It also sequences the multi-cycle multiply/divide unit (MDU) with a busy counter, and stalls decode while HI/LO results are pending.

## Interface

Parameters:

- `MUL_LATENCY`, default 3: MDU cycles for mult/multu. Range 1..`DIV_LATENCY`.
- `DIV_LATENCY`, default 8: MDU cycles for div/divu. Range `MUL_LATENCY`..32.

Ports. One clock; reset is asynchronous and active-low.

- `clk` in 1: rising-edge clock.
- `rst_n` in 1: asynchronous active-low reset.
- `rs_D`, `rt_D` in 5 each: source registers of the instruction in D.
- `branch_D` in 1: the D instruction is a beq/bne, compared in D.
- `branch_taken_D` in 1: the D-stage comparator resolved the branch as taken.
- `mdu_use_D` in 1: the D instruction is mfhi/mflo/mult/multu/div/divu.
- `write_reg_E` in 5: destination register in E.
- `reg_write_E`, `mem_to_reg_E` in 1 each: E writes the register file / E is a load.
- `mdu_start_E` in 1: an MDU instruction is in E this cycle.
- `mdu_op_E` in 1: 0 = multiply, 1 = divide.
- `write_reg_M` in 5: destination register in M.
- `reg_write_M`, `mem_to_reg_M` in 1 each: M writes the register file / M is a load.
- `stall_F`, `stall_D` out 1 each: hold the PC and the IF/ID register.
- `flush_D` out 1: clear the IF/ID register.
- `flush_E` out 1: clear the ID/EX register (insert a bubble).
- `forward_a_D`, `forward_b_D` out 1 each: select the M-stage ALU result for the branch comparator.
- `mdu_busy` out 1: the MDU is computing.
- `mdu_done` out 1: one-cycle pulse; HI/LO are written at the end of this cycle.

## Operation

Combinational hazard terms:

- `match(x, r)` = (`x` != 0) && (`x` == `r`).
- `lw_stall` = `mem_to_reg_E` && `reg_write_E` && (`match(write_reg_E, rs_D)` || `match(write_reg_E, rt_D)`).
- `br_stall` = `branch_D` && ((`reg_write_E` && `match(write_reg_E, rs_D or rt_D)`) || (`mem_to_reg_M` && `match(write_reg_M, rs_D or rt_D)`)).
- `mdu_stall` = `mdu_use_D` && (`mdu_busy` || (`state` == IDLE && `mdu_start_E`)).
- `stall` = `lw_stall` || `br_stall` || `mdu_stall`.

Combinational outputs:

- `stall_F` = `stall_D` = `flush_E` = `stall`.
- `flush_D` = `branch_taken_D` && !`stall`. A stall overrides the squash; the branch re-resolves after the stall clears.
- `forward_a_D` = `reg_write_M` && !`mem_to_reg_M` && `match(write_reg_M, rs_D)`.
- `forward_b_D` is the same as `forward_a_D` with `rt_D`.
- Register 0 never causes a stall or a forward.

MDU sequencer FSM, states IDLE and BUSY, with a down-counter `cnt` of width `$clog2(DIV_LATENCY)`, minimum 1:

- IDLE, `mdu_start_E` = 1: load `cnt` = (`mdu_op_E` ? `DIV_LATENCY` : `MUL_LATENCY`) − 1, then go to BUSY.
- IDLE, otherwise: stay in IDLE.
- BUSY, `cnt` != 0: decrement `cnt`.
- BUSY, `cnt` == 0: assert `mdu_done` this cycle, then go to IDLE.
- Outputs: `mdu_busy` = (`state` == BUSY). `mdu_done` = (`state` == BUSY && `cnt` == 0).
- `mdu_start_E` while BUSY is a protocol violation, because `mdu_stall` prevents it. It is ignored: no reload and no state change.
- `flush_E` does not cancel an accepted MDU start; the instruction in E is valid.

## Timing

- Reset (`rst_n` low, asynchronous): `state` = IDLE, `cnt` = 0, `mdu_busy` = 0, `mdu_done` = 0.
  - While `rst_n` is low, `stall_F`, `stall_D`, `flush_D` and `flush_E` are forced to 0.
  - A reset mid-operation aborts the MDU with no `mdu_done` pulse.
- Hazard and forward outputs are purely combinational from the current inputs and `state`; there are zero cycles of latency.
- MDU start sampled at edge k means:
  - `mdu_busy` = 1 for cycles k+1 through k+L, where L is the selected latency;
  - `mdu_done` = 1 in cycle k+L only;
  - `mdu_busy` = 0 in cycle k+L+1.
- A dependent `mdu_use_D` is stalled through cycle k+L and advances at the end of cycle k+L+1.
- An MDU start arriving in the same cycle the FSM returns to IDLE is not possible, because `mdu_stall` held it off. A start in the cycle after `mdu_done` is accepted normally, giving back-to-back operation.
- `lw_stall` lasts exactly 1 cycle, since the load moves to M.
- `br_stall` lasts 1 cycle after an ALU producer, or 2 cycles after a load producer (one cycle in E, one in M).

## Test plan

1. Load-use: `mem_to_reg_E` = 1, `reg_write_E` = 1, `write_reg_E` = 5, `rs_D` = 5 → `stall_F`/`stall_D`/`flush_E` = 1 for one cycle. Repeat with `write_reg_E` = 0 and `rs_D` = 0 → all 0.
2. Branch after ALU: `branch_D` = 1, `rt_D` = 7, E is an ALU op writing r7 → stall 1 cycle. In the next cycle (r7 now in M, `reg_write_M` = 1) → stall = 0, `forward_b_D` = 1.
3. Branch after load: load to r3 in E, `branch_D` with `rs_D` = 3 → stall 2 consecutive cycles, then `forward_a_D` = 0 since the value comes from WB.
4. Taken branch versus stall: `branch_taken_D` = 1 with `lw_stall` = 1 → `flush_D` = 0. When the stall clears → `flush_D` = 1 for one cycle.
5. Divide: `mdu_start_E` = 1, `mdu_op_E` = 1 at edge k, mflo held in D:
   - `mdu_busy` high for cycles k+1 through k+8;
   - `mdu_done` high only at k+8;
   - stall high from k through k+8, low at k+9.
   - Repeat as a multiply → `mdu_done` at k+3.
6. Reset mid-divide: deassert `rst_n` at cycle k+4 → `mdu_busy` = 0 immediately, no `mdu_done`, stalls = 0. After release, a new multiply starts cleanly.
